// File: rtl/rx_link_fault_ctrl.sv
// rx_link_fault_ctrl: clause-46 link-fault sequencer over two XGMII columns per rxclk.
// Optional LINK_FAULT_STATS_EN adds saturating FAULT-entry counters per fault type.
module rx_link_fault_ctrl #(
    parameter logic [7:0] SEQ_CODE   = 8'h9C,
    parameter int         SEQ_THRESH = 4,
    parameter int         COL_WINDOW = 128,
    parameter int         CNT_W      = 8
) (
    input  logic        rxclk,
    input  logic        reset,
    input  logic [63:0] i_rxd64,
    input  logic [7:0]  i_rxc8,
    output logic [1:0]  o_link_fault,
    output logic        o_tx_send_rf,
    output logic        o_tx_send_idle,
    output logic        o_rx_block
`ifdef LINK_FAULT_STATS_EN
    ,
    output logic [15:0] o_lf_local_cnt,
    output logic [15:0] o_lf_remote_cnt
`endif
);
    localparam logic [CNT_W-1:0] WIN = CNT_W'(COL_WINDOW);
    localparam logic [2:0]       THR = 3'(SEQ_THRESH);

    typedef enum logic [1:0] {INIT, COUNT, FAULT} state_t;

    typedef struct packed {
        state_t           st;
        logic [2:0]       seq;
        logic [CNT_W-1:0] col;
        logic [1:0]       typ;
        logic [1:0]       lf;
        logic             ent;
    } ctx_t;

    ctx_t       r_ctx, w_cur, w_n0, w_n1;
    logic [2:0] w_d0, w_d1;
    logic       r_rf, r_idle, r_blk;

    function automatic logic [2:0] dec(input logic [31:0] d, input logic [3:0] c);
        logic f;
        f = c == 4'b0001 && d[7:0] == SEQ_CODE && d[23:8] == 16'h0000 &&
            (d[31:24] == 8'h01 || d[31:24] == 8'h02);
        return {f, f ? d[25:24] : 2'b00};
    endfunction

    function automatic ctx_t step(input ctx_t c, input logic f, input logic [1:0] t);
        ctx_t             n;
        logic [CNT_W-1:0] col_n;
        logic [2:0]       seq_n;
        n     = c;
        col_n = (c.col == WIN) ? c.col : c.col + 1'b1;
        seq_n = (c.seq == THR) ? c.seq : c.seq + 1'b1;
        if (c.st == INIT) begin
            if (f) begin
                n.st  = COUNT;
                n.typ = t;
                n.seq = 3'd1;
                n.col = '0;
            end
        end else if (f && t == c.typ) begin
            n.col = '0;
            if (c.st == COUNT) begin
                n.seq = seq_n;
                if (seq_n == THR) begin
                    n.st  = FAULT;
                    n.lf  = t;
                    n.ent = 1'b1;
                end
            end
        end else if (f) begin
            // a new type restarts qualification; the reported fault holds meanwhile
            n.st  = COUNT;
            n.typ = t;
            n.seq = 3'd1;
            n.col = '0;
        end else begin
            n.col = col_n;
            if (col_n == WIN) begin
                n.st  = INIT;
                n.lf  = 2'b00;
                n.seq = 3'd0;
                n.typ = 2'b00;
            end
        end
        return n;
    endfunction

    always_comb begin
        w_cur     = r_ctx;
        w_cur.ent = 1'b0;
        w_d0      = dec(i_rxd64[31:0], i_rxc8[3:0]);
        w_d1      = dec(i_rxd64[63:32], i_rxc8[7:4]);
        w_n0      = step(w_cur, w_d0[2], w_d0[1:0]);
        w_n1      = step(w_n0, w_d1[2], w_d1[1:0]);
    end

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            r_ctx  <= '0;
            r_rf   <= 1'b0;
            r_idle <= 1'b0;
            r_blk  <= 1'b0;
        end else begin
            r_ctx  <= w_n1;
            r_rf   <= w_n1.lf == 2'b01;
            r_idle <= w_n1.lf == 2'b10;
            r_blk  <= w_n1.lf != 2'b00;
        end
    end

    assign o_link_fault   = r_ctx.lf;
    assign o_tx_send_rf   = r_rf;
    assign o_tx_send_idle = r_idle;
    assign o_rx_block     = r_blk;

`ifdef LINK_FAULT_STATS_EN
    logic [15:0] r_lcnt, r_rcnt;

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            r_lcnt <= '0;
            r_rcnt <= '0;
        end else begin
            if (w_n1.ent && w_n1.lf == 2'b01 && r_lcnt != 16'hFFFF) r_lcnt <= r_lcnt + 1'b1;
            if (w_n1.ent && w_n1.lf == 2'b10 && r_rcnt != 16'hFFFF) r_rcnt <= r_rcnt + 1'b1;
        end
    end

    assign o_lf_local_cnt  = r_lcnt;
    assign o_lf_remote_cnt = r_rcnt;
`endif
endmodule

// File: tb/tb_rx_link_fault_ctrl.sv
// tb_rx_link_fault_ctrl: directed scenario checks of the link-fault sequencer.
module tb_rx_link_fault_ctrl;
    logic        rxclk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] i_rxd64;
    logic [7:0]  i_rxc8;
    logic [1:0]  o_link_fault;
    logic        o_tx_send_rf, o_tx_send_idle, o_rx_block;
`ifdef LINK_FAULT_STATS_EN
    logic [15:0] o_lf_local_cnt, o_lf_remote_cnt;
`endif
    int checks = 0;
    int failures = 0;

    localparam int IDL = 0, LOC = 1, REM = 2, BAD = 3;
    localparam logic [4:0] OK_V = 5'b00000, LF_V = 5'b01101, RF_V = 5'b10011;

    rx_link_fault_ctrl dut (
        .rxclk(rxclk), .reset(reset), .i_rxd64(i_rxd64), .i_rxc8(i_rxc8),
        .o_link_fault(o_link_fault), .o_tx_send_rf(o_tx_send_rf),
        .o_tx_send_idle(o_tx_send_idle), .o_rx_block(o_rx_block)
`ifdef LINK_FAULT_STATS_EN
        , .o_lf_local_cnt(o_lf_local_cnt), .o_lf_remote_cnt(o_lf_remote_cnt)
`endif
    );

    always #5 rxclk = ~rxclk;

    function automatic logic [35:0] col(input int k);
        return k == LOC ? {4'b0001, 32'h0100009C} :
               k == REM ? {4'b0001, 32'h0200009C} :
               k == BAD ? {4'b0001, 32'h0300009C} : {4'b1111, 32'h07070707};
    endfunction

    function automatic logic [4:0] outs();
        return {o_link_fault, o_tx_send_rf, o_tx_send_idle, o_rx_block};
    endfunction

    task automatic cyc(input int k0, input int k1);
        logic [35:0] a, b;
        a = col(k0);
        b = col(k1);
        i_rxd64 = {b[31:0], a[31:0]};
        i_rxc8  = {b[35:32], a[35:32]};
        @(posedge rxclk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(IDL, IDL);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (outs() !== OK_V) begin
            failures++;
            $display("FAIL reset_outs got=%b exp=%b", outs(), OK_V);
        end
`ifdef LINK_FAULT_STATS_EN
        checks++;
        if (o_lf_local_cnt !== 16'd0 || o_lf_remote_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_cnts got=%0d/%0d exp=0/0", o_lf_local_cnt, o_lf_remote_cnt);
        end
`endif
    endtask

    task automatic test_local_entry();
        do_reset();
        for (int i = 0; i < 3; i++) cyc(LOC, IDL);
        checks++;
        if (outs() !== OK_V) begin
            failures++;
            $display("FAIL local_pre got=%b exp=%b", outs(), OK_V);
        end
        cyc(LOC, IDL);
        checks++;
        if (outs() !== LF_V) begin
            failures++;
            $display("FAIL local_entry got=%b exp=%b", outs(), LF_V);
        end
`ifdef LINK_FAULT_STATS_EN
        checks++;
        if (o_lf_local_cnt !== 16'd1 || o_lf_remote_cnt !== 16'd0) begin
            failures++;
            $display("FAIL local_cnt got=%0d/%0d exp=1/0", o_lf_local_cnt, o_lf_remote_cnt);
        end
`endif
    endtask

    task automatic test_clear();
        for (int i = 0; i < 63; i++) cyc(IDL, IDL);
        checks++;
        if (outs() !== LF_V) begin
            failures++;
            $display("FAIL clear_pre got=%b exp=%b", outs(), LF_V);
        end
        cyc(IDL, IDL);
        checks++;
        if (outs() !== OK_V) begin
            failures++;
            $display("FAIL clear got=%b exp=%b", outs(), OK_V);
        end
    endtask

    task automatic test_remote_dense();
        do_reset();
        cyc(REM, REM);
        checks++;
        if (outs() !== OK_V) begin
            failures++;
            $display("FAIL remote_pre got=%b exp=%b", outs(), OK_V);
        end
        cyc(REM, REM);
        checks++;
        if (outs() !== RF_V) begin
            failures++;
            $display("FAIL remote_entry got=%b exp=%b", outs(), RF_V);
        end
    endtask

    task automatic test_alternating();
        logic [4:0] worst;
        do_reset();
        worst = OK_V;
        for (int i = 0; i < 20; i++) begin
            cyc(LOC, REM);
            if (outs() !== OK_V) worst = outs();
        end
        checks++;
        if (worst !== OK_V) begin
            failures++;
            $display("FAIL alternating got=%b exp=%b", worst, OK_V);
        end
    endtask

    task automatic test_window_expiry();
        do_reset();
        for (int i = 0; i < 3; i++) cyc(LOC, IDL);
        for (int i = 0; i < 64; i++) cyc(IDL, IDL);
        cyc(LOC, IDL);
        checks++;
        if (outs() !== OK_V) begin
            failures++;
            $display("FAIL window_expiry got=%b exp=%b", outs(), OK_V);
        end
        cyc(LOC, IDL);
        cyc(LOC, IDL);
        checks++;
        if (outs() !== OK_V) begin
            failures++;
            $display("FAIL window_recount got=%b exp=%b", outs(), OK_V);
        end
        cyc(LOC, IDL);
        checks++;
        if (outs() !== LF_V) begin
            failures++;
            $display("FAIL window_reentry got=%b exp=%b", outs(), LF_V);
        end
    endtask

    task automatic test_non_fault_cols();
        do_reset();
        for (int i = 0; i < 6; i++) cyc(BAD, BAD);
        cyc(LOC, BAD);
        cyc(LOC, LOC);
        checks++;
        if (outs() !== OK_V) begin
            failures++;
            $display("FAIL bad_seq got=%b exp=%b", outs(), OK_V);
        end
        cyc(LOC, IDL);
        checks++;
        if (outs() !== LF_V) begin
            failures++;
            $display("FAIL bad_seq_entry got=%b exp=%b", outs(), LF_V);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 3; i++) cyc(LOC, IDL);
        cyc(LOC, REM);
        checks++;
        if (outs() !== LF_V) begin
            failures++;
            $display("FAIL switch_hold got=%b exp=%b", outs(), LF_V);
        end
        cyc(REM, REM);
        checks++;
        if (outs() !== LF_V) begin
            failures++;
            $display("FAIL switch_pending got=%b exp=%b", outs(), LF_V);
        end
        cyc(REM, IDL);
        checks++;
        if (outs() !== RF_V) begin
            failures++;
            $display("FAIL switch_confirm got=%b exp=%b", outs(), RF_V);
        end
`ifdef LINK_FAULT_STATS_EN
        checks++;
        if (o_lf_local_cnt !== 16'd1 || o_lf_remote_cnt !== 16'd1) begin
            failures++;
            $display("FAIL switch_cnts got=%0d/%0d exp=1/1", o_lf_local_cnt, o_lf_remote_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid_fault();
        do_reset();
        for (int i = 0; i < 4; i++) cyc(LOC, LOC);
        checks++;
        if (outs() !== LF_V) begin
            failures++;
            $display("FAIL mid_pre got=%b exp=%b", outs(), LF_V);
        end
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (outs() !== OK_V) begin
            failures++;
            $display("FAIL mid_reset got=%b exp=%b", outs(), OK_V);
        end
`ifdef LINK_FAULT_STATS_EN
        checks++;
        if (o_lf_local_cnt !== 16'd0 || o_lf_remote_cnt !== 16'd0) begin
            failures++;
            $display("FAIL mid_cnts got=%0d/%0d exp=0/0", o_lf_local_cnt, o_lf_remote_cnt);
        end
`endif
        @(posedge rxclk);
        #1;
        reset = 1'b0;
        cyc(LOC, LOC);
        cyc(LOC, IDL);
        checks++;
        if (outs() !== OK_V) begin
            failures++;
            $display("FAIL post_reset got=%b exp=%b", outs(), OK_V);
        end
        cyc(LOC, IDL);
        checks++;
        if (outs() !== LF_V) begin
            failures++;
            $display("FAIL post_reset_entry got=%b exp=%b", outs(), LF_V);
        end
    endtask

    initial begin
        i_rxd64 = 64'h0707070707070707;
        i_rxc8  = 8'hFF;
        #2;
        test_reset();
        test_local_entry();
        test_clear();
        test_remote_dense();
        test_alternating();
        test_window_expiry();
        test_non_fault_cols();
        test_back_to_back();
        test_reset_mid_fault();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
